// File: rtl/layer8_sched.sv
// Layer-8 sequencer: walks stages conv14..conv18, output-channel groups, pixels and taps for the shared MAC tree.
// Optional cycle counter port cycle_cnt is built when L8_CYCLE_CNT_EN is defined.
module layer8_sched #(
   parameter int IMG_W   = 8,
   parameter int ACC_LAT = 2,
   parameter int TAPS0   = 8,
   parameter int TAPS1   = 2,
   parameter int TAPS2   = 6,
   parameter int TAPS3   = 12,
   parameter int TAPS4   = 8,
   parameter int GRP0    = 2,
   parameter int GRP1    = 1,
   parameter int GRP2    = 2,
   parameter int GRP3    = 2,
   parameter int GRP4    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [2:0]  u,
   output logic [1:0]  z,
   output logic [3:0]  w_addr,
   output logic [9:0]  rd_addr,
   output logic [9:0]  wr_addr,
   output logic [9:0]  skip_addr,
   output logic        acc_clr,
   output logic        padding,
   output logic        load,
   output logic        busy,
   output logic        done
`ifdef L8_CYCLE_CNT_EN
   ,
   output logic [19:0] cycle_cnt
`endif
);

   localparam int         PIX      = IMG_W * IMG_W;
   localparam logic [9:0] PIX_A    = 10'(PIX);
   localparam logic [9:0] IMG_A    = 10'(IMG_W);
   localparam logic [3:0] COL_LAST = 4'(IMG_W - 1);
   localparam logic [3:0] DRN_LAST = 4'(ACC_LAT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0] state;
   logic [2:0] u_q;
   logic [1:0] z_q;
   logic [3:0] t_q;
   logic [1:0] t3_q;
   logic [2:0] chunk_q;
   logic [9:0] p_q;
   logic [3:0] row_q;
   logic [3:0] col_q;
   logic [3:0] drain_q;

   logic [3:0] taps_cur;
   logic [2:0] grp_cur;
   logic       last_tap;
   logic       last_pix;
   logic       run;
   logic       pad;
   logic [9:0] src;
   logic [9:0] rd_raw;
   logic [9:0] wb_addr;

   logic [ACC_LAT-1:0] dl_vld;
   logic [9:0]         dl_addr [ACC_LAT];

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      taps_cur = 4'(TAPS4);
      grp_cur  = 3'(GRP4);
      case (u_q)
         3'd0: begin taps_cur = 4'(TAPS0); grp_cur = 3'(GRP0); end
         3'd1: begin taps_cur = 4'(TAPS1); grp_cur = 3'(GRP1); end
         3'd2: begin taps_cur = 4'(TAPS2); grp_cur = 3'(GRP2); end
         3'd3: begin taps_cur = 4'(TAPS3); grp_cur = 3'(GRP3); end
         default: ;
      endcase
   end

   assign run      = (state == S_RUN);
   assign last_tap = (t_q == taps_cur - 4'd1);
   assign last_pix = (p_q == PIX_A - 10'd1);
   assign wb_addr  = {8'b0, z_q} * PIX_A + p_q;

   // Separable kernels: t%3 picks the neighbour (-1,0,+1) along the row (u=2) or column (u=3).
   always_comb begin
      pad = 1'b0;
      src = p_q;
      if (u_q == 3'd2 || u_q == 3'd3) begin
         if (t3_q == 2'd0) begin
            pad = (u_q == 3'd2) ? (col_q == 4'd0) : (row_q == 4'd0);
            src = (u_q == 3'd2) ? p_q - 10'd1 : p_q - IMG_A;
         end else if (t3_q == 2'd2) begin
            pad = (u_q == 3'd2) ? (col_q == COL_LAST) : (row_q == COL_LAST);
            src = (u_q == 3'd2) ? p_q + 10'd1 : p_q + IMG_A;
         end
         if (pad) src = p_q;
         rd_raw = {7'b0, chunk_q} * PIX_A + src;
      end else begin
         rd_raw = {6'b0, t_q} * PIX_A + p_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         u_q     <= '0;
         z_q     <= '0;
         t_q     <= '0;
         t3_q    <= '0;
         chunk_q <= '0;
         p_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         drain_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  u_q     <= '0;
                  z_q     <= '0;
                  t_q     <= '0;
                  t3_q    <= '0;
                  chunk_q <= '0;
                  p_q     <= '0;
                  row_q   <= '0;
                  col_q   <= '0;
                  drain_q <= '0;
               end
            end
            S_RUN: begin
               if (last_tap) begin
                  t_q     <= '0;
                  t3_q    <= '0;
                  chunk_q <= '0;
                  if (last_pix) begin
                     p_q   <= '0;
                     row_q <= '0;
                     col_q <= '0;
                     state <= S_DRAIN;
                  end else begin
                     p_q <= p_q + 10'd1;
                     if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + 4'd1;
                     end else begin
                        col_q <= col_q + 4'd1;
                     end
                  end
               end else begin
                  t_q <= t_q + 4'd1;
                  if (t3_q == 2'd2) begin
                     t3_q    <= '0;
                     chunk_q <= chunk_q + 3'd1;
                  end else begin
                     t3_q <= t3_q + 2'd1;
                  end
               end
            end
            S_DRAIN: begin
               // u/z advance only after the group's last load has left the delay line.
               if (drain_q == DRN_LAST) begin
                  drain_q <= '0;
                  if ({1'b0, z_q} == grp_cur - 3'd1) begin
                     z_q <= '0;
                     if (u_q == 3'd4) begin
                        u_q   <= '0;
                        state <= S_DONE;
                     end else begin
                        u_q   <= u_q + 3'd1;
                        state <= S_RUN;
                     end
                  end else begin
                     z_q   <= z_q + 2'd1;
                     state <= S_RUN;
                  end
               end else begin
                  drain_q <= drain_q + 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_vld <= '0;
      end else begin
         for (int i = ACC_LAT - 1; i > 0; i--) dl_vld[i] <= dl_vld[i-1];
         dl_vld[0] <= run && last_tap;
      end
   end

   // NOTE: the address delay line is storage without reset; its valid bits above gate every use of it.
   always_ff @(posedge clk) begin
      for (int i = ACC_LAT - 1; i > 0; i--) dl_addr[i] <= dl_addr[i-1];
      dl_addr[0] <= wb_addr;
   end

`ifdef L8_CYCLE_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
      end else if (state == S_IDLE && start) begin
         cycle_cnt <= '0;
      end else if (busy && cycle_cnt != '1) begin
         cycle_cnt <= cycle_cnt + 20'd1;
      end
   end
`endif

   assign u         = u_q;
   assign z         = z_q;
   assign w_addr    = run ? t_q : '0;
   assign rd_addr   = run ? rd_raw : '0;
   assign acc_clr   = run && (t_q == 4'd0);
   assign padding   = run && pad;
   assign load      = dl_vld[ACC_LAT-1];
   assign wr_addr   = load ? dl_addr[ACC_LAT-1] : '0;
   assign skip_addr = (load && u_q == 3'd4) ? wr_addr : '0;
   assign busy      = run || (state == S_DRAIN);
   assign done      = (state == S_DONE);

endmodule

// File: tb/tb_layer8_sched.sv
// Directed bench for layer8_sched: reset, mid-run abort, one full run with probes at hand-computed cycle offsets.
module tb_layer8_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  u;
   logic [1:0]  z;
   logic [3:0]  w_addr;
   logic [9:0]  rd_addr;
   logic [9:0]  wr_addr;
   logic [9:0]  skip_addr;
   logic        acc_clr;
   logic        padding;
   logic        load;
   logic        busy;
   logic        done;
`ifdef L8_CYCLE_CNT_EN
   logic [19:0] cycle_cnt;
`endif

   layer8_sched dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .u         (u),
      .z         (z),
      .w_addr    (w_addr),
      .rd_addr   (rd_addr),
      .wr_addr   (wr_addr),
      .skip_addr (skip_addr),
      .acc_clr   (acc_clr),
      .padding   (padding),
      .load      (load),
      .busy      (busy),
      .done      (done)
`ifdef L8_CYCLE_CNT_EN
      ,
      .cycle_cnt (cycle_cnt)
`endif
   );

   always #5 clk = ~clk;

   localparam int MAXK = 6000;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] r_u   [MAXK];
   logic [1:0] r_z   [MAXK];
   logic [3:0] r_w   [MAXK];
   logic [9:0] r_rd  [MAXK];
   logic [9:0] r_wr  [MAXK];
   logic [9:0] r_sk  [MAXK];
   logic       r_pad [MAXK];
   logic       r_ld  [MAXK];
   logic       r_clr [MAXK];

   int         k;
   int         load_cnt;
   int         done_cnt;
   bit         seen_done;
   int         useq[$];
   logic [2:0] last_u;
   logic       done_busy;
   logic [2:0] done_u;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Record every busy cycle indexed from the first RUN cycle; optionally pulse start while busy.
   task automatic full_run(input int inject_at);
      k = 0;
      load_cnt = 0;
      done_cnt = 0;
      seen_done = 1'b0;
      useq.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 7000 && !seen_done; c++) begin
         if (busy) begin
            if (k < MAXK) begin
               r_u[k]   = u;
               r_z[k]   = z;
               r_w[k]   = w_addr;
               r_rd[k]  = rd_addr;
               r_wr[k]  = wr_addr;
               r_sk[k]  = skip_addr;
               r_pad[k] = padding;
               r_ld[k]  = load;
               r_clr[k] = acc_clr;
            end
            if (useq.size() == 0 || u != last_u) begin
               useq.push_back(int'(u));
               last_u = u;
            end
            k++;
         end
         if (load) load_cnt++;
         if (done) begin
            done_cnt++;
            seen_done = 1'b1;
            done_busy = busy;
            done_u    = u;
         end
         start = (c == inject_at);
         @(negedge clk);
      end
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (load) load_cnt++;
         if (done) done_cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      int lc;
      int bc;

      #12;
      check("reset_busy_done_load", {busy, done, load, acc_clr, padding}, 0);
      check("reset_addrs", {u, z, w_addr, rd_addr, wr_addr, skip_addr}, 0);
      @(negedge clk) rst = 1'b1;

      // Abort in the middle of stage 0 and confirm nothing leaks out afterwards.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (49) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_w_addr", w_addr, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_ctrl", {busy, done, load, acc_clr, padding}, 0);
      check("mid_rst_addrs", {u, z, w_addr, rd_addr, wr_addr, skip_addr}, 0);
      @(negedge clk) rst = 1'b1;
      lc = 0;
      bc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (load) lc++;
         if (busy) bc++;
      end
      check("post_rst_no_load", lc, 0);
      check("post_rst_idle", bc, 0);
`ifdef L8_CYCLE_CNT_EN
      check("post_rst_cycle_cnt", cycle_cnt, 0);
`endif

      full_run(3000);

      check("done_seen", seen_done, 1);
      check("done_count", done_cnt, 1);
      check("busy_cycles", k, 5526);
      check("load_count", load_cnt, 704);
      check("done_busy_low", done_busy, 0);
      check("done_u_zero", done_u, 0);
      check("u_seq_len", useq.size(), 5);
      for (int i = 0; i < 5 && i < useq.size(); i++) check("u_seq", useq[i], i);
`ifdef L8_CYCLE_CNT_EN
      check("cycle_cnt", cycle_cnt, 5526);
`endif

      // u=0, z=1, pixel 5: last tap at k=561, load two cycles later.
      check("u0_w7", {r_u[561], r_z[561], r_w[561]}, {3'd0, 2'd1, 4'd7});
      check("u0_noload_562", r_ld[562], 0);
      check("u0_load_563", r_ld[563], 1);
      check("u0_wr_563", r_wr[563], 69);
      check("u0_skip_zero", r_sk[563], 0);

      check("u1_rd_p10_t1", {r_u[1049], r_rd[1049]}, {3'd1, 10'd74});

      // u=2, pixel (0,0) taps 0..2.
      check("u2_p0_t0", {r_u[1158], r_clr[1158], r_pad[1158], r_rd[1158]}, {3'd2, 1'b1, 1'b1, 10'd0});
      check("u2_p0_t1", {r_pad[1159], r_rd[1159]}, {1'b0, 10'd0});
      check("u2_p0_t2", {r_pad[1160], r_rd[1160]}, {1'b0, 10'd1});
      check("u2_p7_t2", {r_w[1202], r_pad[1202], r_rd[1202]}, {4'd2, 1'b1, 10'd7});

      // u=3 column kernel.
      check("u3_p27_t0", {r_u[2254], r_pad[2254], r_rd[2254]}, {3'd3, 1'b0, 10'd19});
      check("u3_p27_t4", {r_pad[2258], r_rd[2258]}, {1'b0, 10'd91});
      check("u3_p59_t2", {r_pad[2640], r_rd[2640]}, {1'b1, 10'd59});

      check("u4_rd_p3_t5", {r_u[3499], r_rd[3499]}, {3'd4, 10'd323});
      check("u4_z2", r_z[4498], 2);
      check("u4_last_load", {r_u[5525], r_ld[5525], r_wr[5525], r_sk[5525]}, {3'd4, 1'b1, 10'd255, 10'd255});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
